// File: rtl/serial_unshifter.sv
// serial_unshifter: bit-serial right shifter that undoes a prior left shift.
// One bit position per clock; valid/ready handshake on both sides.
// Optional build macro SERIAL_UNSHIFTER_ROTATE_EN: each step rotates right
// (bit 0 wraps to the MSB) instead of shifting in a zero.
module serial_unshifter #(
  parameter int WIDTH  = 8,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in,
  input  logic [CTRL_W-1:0] ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_data,  w_data_nxt;
  logic [CTRL_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0]    w_step;

  // one-position step of the data register
`ifdef SERIAL_UNSHIFTER_ROTATE_EN
  assign w_step = {r_data[0], r_data[WIDTH-1:1]};
`else
  assign w_step = {1'b0, r_data[WIDTH-1:1]};
`endif

  // handshake/status outputs decoded from state; reset masks in_ready
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out       = r_data;

  // next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_data_nxt  = in;
          w_cnt_nxt   = ctrl;
          w_state_nxt = (ctrl == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        w_data_nxt = w_step;
        w_cnt_nxt  = r_cnt - CTRL_W'(1);
        if (r_cnt == CTRL_W'(1)) w_state_nxt = DONE;
      end
      DONE: begin
        // data holds; it stays visible on out after the handshake
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state and datapath registers; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_serial_unshifter.sv
// Directed self-checking bench for serial_unshifter.
module tb_serial_unshifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in;
  logic [2:0] ctrl;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  serial_unshifter #(.WIDTH(8), .CTRL_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in(in), .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  // advance one edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // full status snapshot
  task automatic chk_st(input string tag, input logic [7:0] e_out, input logic e_ov,
                        input logic e_busy, input logic e_ir);
    chk({tag, ".out"},       32'(out),       32'(e_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, ".busy"},      32'(busy),      32'(e_busy));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
  endtask

  logic [7:0] exp_255, exp_81;

  initial begin
`ifdef SERIAL_UNSHIFTER_ROTATE_EN
    exp_255 = 8'hFF;
    exp_81  = 8'hC0;
`else
    exp_255 = 8'h01;
    exp_81  = 8'h40;
`endif
    rst = 1'b1; in_valid = 1'b0; in = 8'h00; ctrl = 3'd0; out_ready = 1'b0;
    step(); step();
    chk_st("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; #1;
    chk("reset_release.in_ready", 32'(in_ready), 32'd1);

    // 128 >> 4 = 8, out_ready already high
    in = 8'd128; ctrl = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk_st("t1.accept", 8'd128, 1'b0, 1'b1, 1'b0);
    step();
    chk_st("t1.shift1", 8'd64, 1'b0, 1'b1, 1'b0);
    step(); step();
    chk_st("t1.shift3", 8'd16, 1'b0, 1'b1, 1'b0);
    step();
    chk_st("t1.done", 8'd8, 1'b1, 1'b1, 1'b0);
    step();
    chk_st("t1.idle", 8'd8, 1'b0, 1'b0, 1'b1);

    // 255, ctrl=7
    in = 8'd255; ctrl = 3'd7; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk_st("t2.shift6", 8'h00 | (out_valid ? 8'hFF : out), 1'b0, 1'b1, 1'b0);
    step();
    chk_st("t2.done", exp_255, 1'b1, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    chk_st("t2.idle", exp_255, 1'b0, 1'b0, 1'b1);

    // ctrl=0 passes through in one cycle
    in = 8'h5A; ctrl = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk_st("t3.done", 8'h5A, 1'b1, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    chk_st("t3.idle", 8'h5A, 1'b0, 1'b0, 1'b1);

    // 0x81 ctrl=1, consumer stalls 5 cycles; new request must be ignored
    in = 8'h81; ctrl = 3'd1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in = 8'hFF; ctrl = 3'd3;
    step();
    for (int i = 0; i < 5; i++) begin
      chk_st("t4.hold", exp_81, 1'b1, 1'b1, 1'b0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_st("t4.idle", exp_81, 1'b0, 1'b0, 1'b1);

    // reset in the middle of SHIFT
    in = 8'd128; ctrl = 3'd5; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk_st("t5.shift1", 8'd64, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; #1;
    chk("t5.rst.in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0; #1;
    chk_st("t5.aborted", 8'h00, 1'b0, 1'b0, 1'b1);
    in = 8'd64; ctrl = 3'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk_st("t5.done", 8'd16, 1'b1, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    chk_st("t5.idle", 8'd16, 1'b0, 1'b0, 1'b1);

    // back-to-back with in_valid held: 0x30>>2 then 0xC0>>1
    in = 8'h30; ctrl = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in = 8'hC0; ctrl = 3'd1;
    chk_st("t6.acc1", 8'h30, 1'b0, 1'b1, 1'b0);
    step();
    chk_st("t6.shift", 8'h18, 1'b0, 1'b1, 1'b0);
    step();
    chk_st("t6.done1", 8'h0C, 1'b1, 1'b1, 1'b0);
    step();
    chk_st("t6.hs1", 8'h0C, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk_st("t6.acc2", 8'hC0, 1'b0, 1'b1, 1'b0);
    step();
    chk_st("t6.done2", 8'h60, 1'b1, 1'b1, 1'b0);
    step();
    chk_st("t6.idle", 8'h60, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
